// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Data normally wins a collision. A starvation counter
// lets a waiting fetch through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_grant_i;
  logic        w_grant_d;
  logic [3:0]  r_starve_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_valid;
  logic        r_d_valid;

  // State register; reset drops any in-flight access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Arbitration and next state: data wins unless the fetch has waited too long.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && !(i_req && (r_starve_cnt == LIMIT))) begin
          w_grant_d    = 1'b1;
          w_state_next = DBUSY;
        end else if (i_req) begin
          w_grant_i    = 1'b1;
          w_state_next = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Starvation counter: counts data grants made while a fetch is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_d && i_req) begin
      if (r_starve_cnt < LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else if (w_grant_i) begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Memory command capture on grant, read-data capture and valid pulse on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_i_rdata   <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_i_valid <= (r_state == IBUSY) && mem_ack;
      r_d_valid <= (r_state == DBUSY) && mem_ack;
      if (w_grant_d) begin
        r_mem_addr  <= d_addr;
        r_mem_we    <= d_we;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_mem_addr <= i_addr;
        r_mem_we   <= 1'b0;
      end
      if ((r_state == IBUSY) && mem_ack) begin
        r_i_rdata <= mem_rdata;
      end
      // Writes complete without touching the last read value.
      if ((r_state == DBUSY) && mem_ack && !r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state != IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_valid   = r_i_valid;
  assign i_rdata   = r_i_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;

endmodule
